frame_capture_stream: RTL and testbench
=======================================

Name: frame_capture_stream

Overview:
Synthesizable successor to the simulation-only frame dump. Snoops the pixel stream at the output multiplexer (x, y, r, g, b plus a pixel-clock enable). On request it captures 1..255 whole active frames, optionally decimated. Captured pixels are streamed out over AXI-Stream with start-of-frame and end-of-frame markers for DMA to memory. Sits beside the multiplexer, before the HDMI controller.

Parameters:
SCREEN_WIDTH, 640, active pixels per line
SCREEN_HEIGHT, 480, active lines
H_TOTAL, 800, pixels per line including blanking
V_TOTAL, 525, lines per frame including blanking
LOG2_DECIM, 0, spatial decimation; keep every 2^LOG2_DECIM-th pixel and line. SCREEN_WIDTH and SCREEN_HEIGHT must be multiples of it.
FIFO_DEPTH, 64, output FIFO entries; power of 2, at least 4

Ports:
clk  in  1  single system clock
resetn  in  1  asynchronous active-low reset
pix_en  in  1  one-cycle strobe; x/y/r/g/b are valid for a new pixel
x  in  10  pixel column counter, 0..H_TOTAL-1
y  in  10  line counter, 0..V_TOTAL-1
r, g, b  in  8 each  pixel colour
capture_req  in  1  start capture (level-sampled)
num_frames  in  8  frames to capture; 0 is treated as 1
busy  out  1  capture or drain in progress
overflow  out  1  sticky; an eligible pixel was dropped
frames_done  out  8  frames completed in the current request
m_axis_tdata  out  24  pixel word {r,g,b}, r in [23:16]
m_axis_tvalid  out  1  AXI-Stream valid
m_axis_tready  in  1  AXI-Stream ready
m_axis_tlast  out  1  last pixel of a frame
m_axis_tuser  out  1  first pixel of a frame

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty. busy=0, overflow=0, frames_done=0, tvalid=0, tlast=0, tuser=0, tdata=0.
- State IDLE: capture_req=1 latches remaining=max(num_frames,1), clears overflow and frames_done, moves to ARMED. busy=1 in every state except IDLE.
- State ARMED: waits for pix_en with x==H_TOTAL-1 and y==V_TOTAL-1, then moves to CAPTURE. Capture therefore always starts at pixel (0,0) and partial frames are never captured.
- State CAPTURE: a pixel is eligible on pix_en when all of the following hold:
  - x<SCREEN_WIDTH and y<SCREEN_HEIGHT;
  - the low LOG2_DECIM bits of x are 0;
  - the low LOG2_DECIM bits of y are 0.
- Eligible pixels are pushed into the FIFO together with two flags:
  - sof is set on (0,0);
  - eof is set on (SCREEN_WIDTH-2^LOG2_DECIM, SCREEN_HEIGHT-2^LOG2_DECIM).
- On the eof pixel, whether it was pushed or dropped:
  - frames_done increments and remaining decrements;
  - if remaining becomes 0 the state moves to DRAIN, otherwise to ARMED.
- State DRAIN: when the FIFO is empty and no beat is pending, the state moves to IDLE.
- capture_req is ignored while busy.
- Full rule: a non-eof pixel is dropped when occupancy ≥ FIFO_DEPTH-1. This keeps one slot reserved for eof. An eof pixel is dropped only when occupancy == FIFO_DEPTH. Any drop sets overflow. A dropped eof means that frame has no tlast; software detects this through overflow.
- Latency: a pixel pushed at edge N appears on m_axis at edge N+1 if the FIFO was empty.
- AXI rules: tdata, tlast and tuser are held stable while tvalid=1 and tready=0. A beat transfers when tvalid and tready are both high. A push and a pop may occur in the same cycle when the FIFO is full; occupancy is then unchanged.
- Occupancy arithmetic uses log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- pix_en with out-of-range x or y (≥ H_TOTAL or ≥ V_TOTAL) is ignored; it is never eligible and never arms.
- A reset mid-capture discards FIFO contents. No partial beat is emitted after reset.

Optional Feature:
FRAME_CAPTURE_CHECKSUM_EN adds two outputs:
- frame_checksum (32 bits): the modulo-2^32 sum of the zero-extended 24-bit words of all eligible pixels in the frame, including dropped ones.
- checksum_valid (1 bit): a one-cycle pulse on the cycle after the eof pixel, with frame_checksum stable from then until the next eof.
- Both outputs reset to 0 and the sum restarts at sof.
Without the macro these ports and the accumulator do not exist, and nothing else changes.

Test Plan:
1. Config SCREEN_WIDTH=8, SCREEN_HEIGHT=4, H_TOTAL=10, V_TOTAL=6, LOG2_DECIM=0. Pattern r=x, g=y, b=x^y, tready=1, num_frames=1. Expect exactly 32 beats in raster order. Beat 0 has tuser=1 with tdata=0x000000. Beat 31 has tlast=1 with tdata=0x070304. Then busy falls and frames_done=1.
2. Same pattern with LOG2_DECIM=1. Expect 8 beats: (0,0),(2,0),(4,0),(6,0),(0,2),(2,2),(4,2),(6,2). tlast only on (6,2).
3. num_frames=3, with capture_req asserted mid-frame. Expect:
   - the first beat comes from the next (0,0);
   - 96 beats, 3 tuser and 3 tlast;
   - frames_done=3 and overflow=0;
   - a second capture_req while busy has no effect.
4. FIFO_DEPTH=8, tready=0 for the whole frame of test 1. Expect overflow=1. After tready=1, exactly 8 beats emerge: pixels 0..6, then the eof word 0x070304 with tlast.
5. Assert resetn low during CAPTURE, after 10 pixels. Expect tvalid=0 and busy=0 immediately (asynchronous), and FIFO empty. After release, capture_req works normally.
6. (FRAME_CAPTURE_CHECKSUM_EN) Constant r=g=b=0x01 over the test 1 frame. Expect one checksum_valid pulse with frame_checksum=32×0x010101=0x00202020. Also run test 4 and check the checksum still covers all 32 pixels.

Source files
------------

// File: rtl/frame_capture_stream.sv
// Captures 1..255 whole active frames from the pixel mux and streams them out over AXI-Stream.
// Optional macro FRAME_CAPTURE_CHECKSUM_EN adds a per-frame 32-bit checksum output.
module frame_capture_stream #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int H_TOTAL       = 800,
    parameter int V_TOTAL       = 525,
    parameter int LOG2_DECIM    = 0,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pix_en,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        capture_req,
    input  logic [7:0]  num_frames,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  frames_done,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    ,
    output logic [31:0] frame_checksum,
    output logic        checksum_valid
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DSTEP = 1 << LOG2_DECIM;

    localparam logic [9:0]  SW_C      = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  SH_C      = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]  HT_C      = 10'(H_TOTAL);
    localparam logic [9:0]  VT_C      = 10'(V_TOTAL);
    localparam logic [9:0]  HLAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VLAST_C   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  EOF_X_C   = 10'(SCREEN_WIDTH - DSTEP);
    localparam logic [9:0]  EOF_Y_C   = 10'(SCREEN_HEIGHT - DSTEP);
    localparam logic [9:0]  DMASK_C   = 10'(DSTEP - 1);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_M1_C = (AW + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

    state_t        state_q;
    logic [7:0]    remaining_q;
    logic [7:0]    frames_done_q;
    logic          overflow_q;

    logic [25:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [23:0]   tdata_q;
    logic          tvalid_q, tlast_q, tuser_q;

    logic          in_range, last_pix, eligible, is_sof, is_eof;
    logic          pop, push, drop, load;
    logic [AW:0]   occ_eff, mem_count;

    assign in_range = pix_en && (x < HT_C) && (y < VT_C);
    assign last_pix = in_range && (x == HLAST_C) && (y == VLAST_C);
    assign eligible = (state_q == S_CAPTURE) && in_range && (x < SW_C) && (y < SH_C)
                      && ((x & DMASK_C) == 10'd0) && ((y & DMASK_C) == 10'd0);
    assign is_sof   = (x == 10'd0) && (y == 10'd0);
    assign is_eof   = (x == EOF_X_C) && (y == EOF_Y_C);

    // A beat leaving this cycle frees its slot for a simultaneous push; one slot stays reserved for eof.
    assign pop       = tvalid_q && m_axis_tready;
    assign occ_eff   = count_q - {{AW{1'b0}}, pop};
    assign push      = eligible && (is_eof ? (occ_eff != DEPTH_C) : (occ_eff < DEPTH_M1_C));
    assign drop      = eligible && !push;
    assign mem_count = count_q - {{AW{1'b0}}, tvalid_q};
    assign load      = (mem_count != '0) && (!tvalid_q || m_axis_tready);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= {is_sof, is_eof, r, g, b};
    end

    // Output register doubles as the registered RAM read and holds the beat under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) begin
                {tuser_q, tlast_q, tdata_q} <= mem[rd_ptr_q];
                tvalid_q <= 1'b1;
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end else if (pop) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            frames_done_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (capture_req) begin
                        remaining_q   <= (num_frames == 8'd0) ? 8'd1 : num_frames;
                        frames_done_q <= '0;
                        overflow_q    <= 1'b0;
                        state_q       <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (last_pix)
                        state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (drop)
                        overflow_q <= 1'b1;
                    if (eligible && is_eof) begin
                        frames_done_q <= frames_done_q + 8'd1;
                        remaining_q   <= remaining_q - 8'd1;
                        state_q       <= (remaining_q == 8'd1) ? S_DRAIN : S_ARMED;
                    end
                end
                S_DRAIN: begin
                    if (count_q == '0)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
    logic [31:0] sum_q, sum_d, checksum_q;
    logic        checksum_valid_q;

    assign sum_d = (is_sof ? 32'd0 : sum_q) + {8'd0, r, g, b};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_q            <= '0;
            checksum_q       <= '0;
            checksum_valid_q <= 1'b0;
        end else begin
            checksum_valid_q <= 1'b0;
            if (eligible) begin
                sum_q <= sum_d;
                if (is_eof) begin
                    checksum_q       <= sum_d;
                    checksum_valid_q <= 1'b1;
                end
            end
        end
    end

    assign frame_checksum = checksum_q;
    assign checksum_valid = checksum_valid_q;
`endif

    assign busy          = (state_q != S_IDLE);
    assign overflow      = overflow_q;
    assign frames_done   = frames_done_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_frame_capture_stream.sv
// Bench for frame_capture_stream: three instances (full-res, decimated, shallow FIFO) share one pixel stream.
module tb_frame_capture_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, pix_en, capture_req;
    logic [9:0] x, y;
    logic [7:0] r, g, b, num_frames;

    logic        tready_a, busy_a, overflow_a, tvalid_a, tlast_a, tuser_a;
    logic        tready_b, busy_b, overflow_b, tvalid_b, tlast_b, tuser_b;
    logic        tready_c, busy_c, overflow_c, tvalid_c, tlast_c, tuser_c;
    logic [7:0]  fd_a, fd_b, fd_c;
    logic [23:0] tdata_a, tdata_b, tdata_c;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    logic [31:0] cs_a, cs_b, cs_c;
    logic        csv_a, csv_b, csv_c;
`endif

    frame_capture_stream #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .H_TOTAL(10), .V_TOTAL(6),
                           .LOG2_DECIM(0), .FIFO_DEPTH(64)) dut_a (
        .clk(clk), .resetn(resetn), .pix_en(pix_en), .x(x), .y(y), .r(r), .g(g), .b(b),
        .capture_req(capture_req), .num_frames(num_frames), .busy(busy_a), .overflow(overflow_a),
        .frames_done(fd_a), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
        .m_axis_tready(tready_a), .m_axis_tlast(tlast_a), .m_axis_tuser(tuser_a)
`ifdef FRAME_CAPTURE_CHECKSUM_EN
        , .frame_checksum(cs_a), .checksum_valid(csv_a)
`endif
    );

    frame_capture_stream #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .H_TOTAL(10), .V_TOTAL(6),
                           .LOG2_DECIM(1), .FIFO_DEPTH(64)) dut_b (
        .clk(clk), .resetn(resetn), .pix_en(pix_en), .x(x), .y(y), .r(r), .g(g), .b(b),
        .capture_req(capture_req), .num_frames(num_frames), .busy(busy_b), .overflow(overflow_b),
        .frames_done(fd_b), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
        .m_axis_tready(tready_b), .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b)
`ifdef FRAME_CAPTURE_CHECKSUM_EN
        , .frame_checksum(cs_b), .checksum_valid(csv_b)
`endif
    );

    frame_capture_stream #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .H_TOTAL(10), .V_TOTAL(6),
                           .LOG2_DECIM(0), .FIFO_DEPTH(8)) dut_c (
        .clk(clk), .resetn(resetn), .pix_en(pix_en), .x(x), .y(y), .r(r), .g(g), .b(b),
        .capture_req(capture_req), .num_frames(num_frames), .busy(busy_c), .overflow(overflow_c),
        .frames_done(fd_c), .m_axis_tdata(tdata_c), .m_axis_tvalid(tvalid_c),
        .m_axis_tready(tready_c), .m_axis_tlast(tlast_c), .m_axis_tuser(tuser_c)
`ifdef FRAME_CAPTURE_CHECKSUM_EN
        , .frame_checksum(cs_c), .checksum_valid(csv_c)
`endif
    );

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
    } beat_t;

    typedef struct {
        int          px;
        int          py;
        logic [23:0] data;
        logic        last;
    } vec_t;

    beat_t q_a[$], q_b[$], q_c[$], exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cs_cnt_a = 0, cs_cnt_b = 0, cs_cnt_c = 0;
    logic [31:0] cs_val_a = '0, cs_val_b = '0, cs_val_c = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (tvalid_a && tready_a) q_a.push_back({tdata_a, tuser_a, tlast_a});
            if (tvalid_b && tready_b) q_b.push_back({tdata_b, tuser_b, tlast_b});
            if (tvalid_c && tready_c) q_c.push_back({tdata_c, tuser_c, tlast_c});
        end
    end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
    always @(negedge clk) begin
        if (resetn) begin
            if (csv_a) begin cs_cnt_a++; cs_val_a = cs_a; end
            if (csv_b) begin cs_cnt_b++; cs_val_b = cs_b; end
            if (csv_c) begin cs_cnt_c++; cs_val_c = cs_c; end
        end
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pat(input int px, input int py);
        logic [7:0] xb, yb;
        xb = 8'(px);
        yb = 8'(py);
        return {xb, yb, xb ^ yb};
    endfunction

    // Raster-order model of a full-resolution capture.
    task automatic build_exp(input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++)
            for (int py = 0; py < 4; py++)
                for (int px = 0; px < 8; px++)
                    exp_q.push_back({pat(px, py), (px == 0 && py == 0), (px == 7 && py == 3)});
    endtask

    task automatic send_frame(input bit const_mode, input int req_at);
        for (int i = 0; i < 60; i++) begin
            pix_en      = 1'b1;
            x           = 10'(i % 10);
            y           = 10'(i / 10);
            r           = const_mode ? 8'h01 : 8'(i % 10);
            g           = const_mode ? 8'h01 : 8'(i / 10);
            b           = const_mode ? 8'h01 : (8'(i % 10) ^ 8'(i / 10));
            capture_req = (i == req_at);
            step();
        end
        pix_en      = 1'b0;
        capture_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit incl_c);
        int n = 0;
        while ((busy_a || busy_b || (incl_c && busy_c)) && n < 500) begin
            step();
            n++;
        end
        check(name, {31'd0, busy_a || busy_b || (incl_c && busy_c)}, 32'd0);
    endtask

    task automatic compare_beats(input string tag, input beat_t act[$], input beat_t exp[$]);
        check({tag, "_count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++) begin
            $display("%s beat %0d data=%06h user=%0b last=%0b", tag, i, act[i].data, act[i].user, act[i].last);
            check($sformatf("%s_beat%0d", tag, i), {6'd0, act[i]}, {6'd0, exp[i]});
        end
    endtask

    task automatic clear_logs();
        q_a.delete(); q_b.delete(); q_c.delete();
        cs_cnt_a = 0; cs_cnt_b = 0; cs_cnt_c = 0;
    endtask

    initial begin
        vec_t       vb [8];
        logic [31:0] pat_sum;
        int          users, lasts;

        vb[0] = '{0, 0, 24'h000000, 1'b0};
        vb[1] = '{2, 0, 24'h020002, 1'b0};
        vb[2] = '{4, 0, 24'h040004, 1'b0};
        vb[3] = '{6, 0, 24'h060006, 1'b0};
        vb[4] = '{0, 2, 24'h000202, 1'b0};
        vb[5] = '{2, 2, 24'h020200, 1'b0};
        vb[6] = '{4, 2, 24'h040206, 1'b0};
        vb[7] = '{6, 2, 24'h060204, 1'b1};

        pat_sum = '0;
        for (int py = 0; py < 4; py++)
            for (int px = 0; px < 8; px++)
                pat_sum = pat_sum + {8'd0, pat(px, py)};

        resetn = 1'b0; pix_en = 1'b0; capture_req = 1'b0; num_frames = 8'd0;
        x = '0; y = '0; r = '0; g = '0; b = '0;
        tready_a = 1'b1; tready_b = 1'b1; tready_c = 1'b0;
        repeat (3) step();
        check("rst_busy", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
        check("rst_overflow", {29'd0, overflow_a, overflow_b, overflow_c}, 32'd0);
        check("rst_frames_done", {8'd0, fd_a, fd_b, fd_c}, 32'd0);
        check("rst_axis_flags", {23'd0, tvalid_a, tlast_a, tuser_a, tvalid_b, tlast_b, tuser_b,
                                 tvalid_c, tlast_c, tuser_c}, 32'd0);
        check("rst_tdata", {8'd0, tdata_a | tdata_b | tdata_c}, 32'd0);
        resetn = 1'b1;
        repeat (2) step();

        // One frame, num_frames=0 meaning one; dut_c is held off with tready low.
        send_frame(1'b0, 30);
        send_frame(1'b0, -1);
        repeat (4) step();
        wait_idle("t1_idle", 1'b0);
        check("t1_frames_done_a", {24'd0, fd_a}, 32'd1);
        check("t1_overflow_a", {31'd0, overflow_a}, 32'd0);
        build_exp(1);
        compare_beats("t1_a", q_a, exp_q);

        check("t2_count", q_b.size(), 32'd8);
        for (int i = 0; i < 8 && i < q_b.size(); i++) begin
            $display("t2_b beat %0d (%0d,%0d) data=%06h user=%0b last=%0b", i, vb[i].px, vb[i].py,
                     q_b[i].data, q_b[i].user, q_b[i].last);
            check($sformatf("t2_b_beat%0d", i), {6'd0, q_b[i]},
                  {6'd0, vb[i].data, (vb[i].px == 0 && vb[i].py == 0), vb[i].last});
        end
        check("t2_frames_done_b", {24'd0, fd_b}, 32'd1);

        check("t4_overflow_c", {31'd0, overflow_c}, 32'd1);
        check("t4_busy_c_held", {31'd0, busy_c}, 32'd1);
`ifdef FRAME_CAPTURE_CHECKSUM_EN
        check("t6_cs_pulses_a", cs_cnt_a, 32'd1);
        check("t6_cs_value_a", cs_val_a, pat_sum);
        check("t6_cs_pulses_c", cs_cnt_c, 32'd1);
        check("t6_cs_value_c_dropped", cs_val_c, pat_sum);
`endif
        tready_c = 1'b1;
        wait_idle("t4_idle", 1'b1);
        build_exp(1);
        exp_q = exp_q[0:6];
        exp_q.push_back({24'h070304, 1'b0, 1'b1});
        compare_beats("t4_c", q_c, exp_q);
        check("t4_frames_done_c", {24'd0, fd_c}, 32'd1);

        // Three frames, request lands mid-frame; a repeat request while busy is ignored.
        clear_logs();
        num_frames = 8'd3;
        send_frame(1'b0, 25);
        num_frames = 8'd1;
        send_frame(1'b0, 10);
        send_frame(1'b0, -1);
        send_frame(1'b0, -1);
        repeat (4) step();
        wait_idle("t3_idle", 1'b1);
        build_exp(3);
        compare_beats("t3_a", q_a, exp_q);
        users = 0; lasts = 0;
        foreach (q_a[i]) begin
            users += int'(q_a[i].user);
            lasts += int'(q_a[i].last);
        end
        check("t3_tuser_count", users, 32'd3);
        check("t3_tlast_count", lasts, 32'd3);
        check("t3_frames_done_a", {24'd0, fd_a}, 32'd3);
        check("t3_overflow", {30'd0, overflow_a, overflow_c}, 32'd0);
        send_frame(1'b0, -1);
        repeat (4) step();
        check("t3_no_rearm_beats", q_a.size(), 32'd96);
        check("t3_no_rearm_busy", {31'd0, busy_a}, 32'd0);

`ifdef FRAME_CAPTURE_CHECKSUM_EN
        clear_logs();
        num_frames = 8'd1;
        send_frame(1'b1, 0);
        send_frame(1'b1, -1);
        repeat (4) step();
        wait_idle("t6_idle", 1'b1);
        check("t6_const_pulses_a", cs_cnt_a, 32'd1);
        check("t6_const_value_a", cs_val_a, 32'h00202020);
        check("t6_const_value_b", cs_val_b, 32'h00080808);
`endif

        // Asynchronous reset in the middle of a captured frame.
        clear_logs();
        num_frames = 8'd1;
        send_frame(1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            pix_en = 1'b1; x = 10'(i); y = 10'd0;
            r = 8'(i); g = 8'd0; b = 8'(i);
            step();
        end
        pix_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("t5_tvalid_async", {30'd0, tvalid_a, tvalid_c}, 32'd0);
        check("t5_busy_async", {30'd0, busy_a, busy_c}, 32'd0);
        repeat (2) step();
        resetn = 1'b1;
        clear_logs();
        repeat (5) step();
        check("t5_fifo_empty", q_a.size() + q_c.size(), 32'd0);
        check("t5_tvalid_after", {30'd0, tvalid_a, tvalid_c}, 32'd0);
        send_frame(1'b0, 0);
        send_frame(1'b0, -1);
        repeat (4) step();
        wait_idle("t5_idle", 1'b1);
        build_exp(1);
        compare_beats("t5_a", q_a, exp_q);
        check("t5_frames_done_a", {24'd0, fd_a}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
